picorv32_mem_bridge: RTL



---
 rtl/picorv32_mem_pkg.sv | 16 +
 rtl/picorv32_mem_bridge.sv | 124 ++++++++++++
 2 files changed

// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-interface to SRAM bridge.
package picorv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv32_mem_bridge.sv
// Registered bridge from the picorv32 native memory port to a single-port
// synchronous SRAM, with address windowing, read latency and sticky fault capture.
module picorv32_mem_bridge
  import picorv32_mem_pkg::*;
#(
  parameter int          AW        = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic          mem_instr,
  input  logic [31:0]   mem_addr,
  input  logic [31:0]   mem_wdata,
  input  logic [3:0]    mem_wstrb,
  output logic          mem_ready,
  output logic [31:0]   mem_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [3:0]    sram_wmask,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  input  logic [31:0]   sram_dout,
  input  logic          err_clr,
  output logic          err,
  output logic [31:0]   err_addr,
  output logic          err_instr
);

  // Out-of-range RD_LAT values are pinned to the nearest legal latency.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam logic [1:0] LAT_LAST = 2'(LAT - 1);

  state_t          state;
  state_t          state_nx;
  logic [1:0]      lat_cnt;
  logic [AW-1:0]   req_word;
  logic [31:0]     req_wdata;
  logic [3:0]      req_wstrb;
  logic            in_range;
  logic            accept;
  logic            fault;

  assign in_range  = (mem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign accept    = (state == IDLE) && mem_valid;
  assign fault     = accept && !in_range;
  assign sram_addr = req_word;
  assign sram_din  = req_wdata;

  always_comb begin
    state_nx   = state;
    mem_ready  = 1'b0;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_wmask = 4'b0000;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          state_nx = in_range ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        sram_ce    = 1'b1;
        sram_we    = |req_wstrb;
        sram_wmask = req_wstrb;
        state_nx   = (|req_wstrb) ? RESP : WAIT;
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        mem_ready = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Out-of-range reads answer straight from IDLE, so ERR_DATA is loaded there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= 2'd0;
      req_word  <= '0;
      req_wdata <= 32'h0;
      req_wstrb <= 4'b0000;
      mem_rdata <= 32'h0;
    end else begin
      state   <= state_nx;
      lat_cnt <= (state == WAIT) ? lat_cnt + 2'd1 : 2'd0;
      if (accept) begin
        req_word  <= mem_addr[AW+1:2];
        req_wdata <= mem_wdata;
        req_wstrb <= mem_wstrb;
      end
      if (fault && (mem_wstrb == 4'b0000)) begin
        mem_rdata <= ERR_DATA;
      end else if ((state == WAIT) && (state_nx == RESP)) begin
        mem_rdata <= sram_dout;
      end
    end
  end

  // A fresh fault takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err       <= 1'b0;
      err_addr  <= 32'h0;
      err_instr <= 1'b0;
    end else if (fault && (!err || err_clr)) begin
      err       <= 1'b1;
      err_addr  <= mem_addr;
      err_instr <= mem_instr;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule
